// File: rtl/sobel_pkg.sv
`default_nettype none
// sobel_pkg -- shared pixel widths and feeder state encoding for the Sobel-X front end.
// SOBEL_FEEDER_FLUSH_EN adds the two trailing flush states to the feeder FSM.
package sobel_pkg;

  localparam int PIX_W = 8;
  localparam int INT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1
`ifdef SOBEL_FEEDER_FLUSH_EN
    ,
    ST_FLUSH1 = 2'd2,
    ST_FLUSH2 = 2'd3
`endif
  } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/sobel_row_buffer.sv
`default_nettype none
// sobel_row_buffer -- COLS x PIX_W register bank, per-column write enable and per-column zero-fill.
// Write wins over clear on the same column.
module sobel_row_buffer
  import sobel_pkg::*;
#(
  parameter int COLS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLS-1:0]       wr_en,
  input  logic [COLS-1:0]       clr,
  input  logic [COLS*PIX_W-1:0] wr_data,
  output logic [COLS*PIX_W-1:0] row
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (wr_en[c]) begin
          row[c*PIX_W +: PIX_W] <= wr_data[c*PIX_W +: PIX_W];
        end else if (clr[c]) begin
          row[c*PIX_W +: PIX_W] <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sobel_row_feeder.sv
`default_nettype none
// sobel_row_feeder -- deserialises a raster pixel stream into COLS-wide row vectors for the Sobel-X array.
// SOBEL_FEEDER_FLUSH_EN appends two all-zero rows after each frame to drain the array.
module sobel_row_feeder
  import sobel_pkg::*;
#(
  parameter int COLS   = 8,
  parameter int RIDX_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIX_W-1:0]      s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_sof,
  input  logic                  s_eof,
  output logic [COLS*PIX_W-1:0] m_row,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic [RIDX_W-1:0]     m_row_idx
);

  localparam int               COL_W    = $clog2(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
`ifdef SOBEL_FEEDER_FLUSH_EN
  localparam feeder_state_t    EOF_NEXT = ST_FLUSH1;
`else
  localparam feeder_state_t    EOF_NEXT = ST_IDLE;
`endif

  feeder_state_t         state;
  logic [COL_W-1:0]      col;
  logic                  fill_full;
  logic                  fill_sof;
  logic [RIDX_W-1:0]     fill_idx;
  logic [RIDX_W-1:0]     row_cnt;
  logic [COLS*PIX_W-1:0] fill_row;

  logic                  flushing;
  logic                  accept;
  logic                  take;
  logic                  complete;
  logic                  out_free;
  logic                  ld_direct;
  logic                  ld_fill;
  logic                  ld_flush;
  logic                  ld_row;
  logic [COL_W-1:0]      wcol;
  logic [RIDX_W-1:0]     tag_idx;
  logic                  tag_sof;
  logic                  ld_sof;
  logic [RIDX_W-1:0]     ld_idx;
  logic [RIDX_W-1:0]     ld_idx_inc;
  logic [COLS-1:0]       fill_we;
  logic [COLS-1:0]       fill_clr;
  logic [COLS*PIX_W-1:0] pix_bcast;
  logic [COLS*PIX_W-1:0] merged;
  logic [COLS*PIX_W-1:0] out_data;

`ifdef SOBEL_FEEDER_FLUSH_EN
  assign flushing = (state == ST_FLUSH1) || (state == ST_FLUSH2);
`else
  assign flushing = 1'b0;
`endif

  assign s_ready = !fill_full && !flushing;
  assign accept  = s_valid && s_ready;
  // Only pixels belonging to a frame are stored; IDLE discards until a sof arrives.
  assign take     = accept && (s_sof || (state == ST_FILL));
  assign wcol     = s_sof ? '0 : col;
  assign complete = take && (s_eof || (wcol == LAST_COL));
  assign out_free = !m_valid || m_ready;

  assign tag_idx = s_sof ? '0 : row_cnt;
  assign tag_sof = (tag_idx == '0);

  assign ld_direct = complete && out_free;
  assign ld_fill   = fill_full && out_free;
  assign ld_flush  = flushing && !fill_full && out_free;
  assign ld_row    = ld_direct || ld_fill;

  always_comb begin
    ld_sof = 1'b0;
    ld_idx = row_cnt;
    if (ld_direct) begin
      ld_sof = tag_sof;
      ld_idx = tag_idx;
    end else if (ld_fill) begin
      ld_sof = fill_sof;
      ld_idx = fill_idx;
    end
  end

  assign ld_idx_inc = (ld_idx == {RIDX_W{1'b1}}) ? ld_idx : ld_idx + 1'b1;

  // The completing pixel is still in flight at the transfer edge, so the output
  // register loads a bypass of the fill contents, the new pixel and the zero tail.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam logic [COL_W-1:0] CI = COL_W'(c);
    assign fill_we[c]                  = take && (wcol == CI);
    assign fill_clr[c]                 = complete && (CI > wcol);
    assign pix_bcast[c*PIX_W +: PIX_W] = s_data;
    assign merged[c*PIX_W +: PIX_W]    = (CI == wcol) ? s_data :
                                         (CI < wcol)  ? fill_row[c*PIX_W +: PIX_W] : '0;
  end

  assign out_data = ld_direct ? merged : fill_row;

  sobel_row_buffer #(.COLS(COLS)) u_fill (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fill_we),
    .clr     (fill_clr),
    .wr_data (pix_bcast),
    .row     (fill_row)
  );

  sobel_row_buffer #(.COLS(COLS)) u_out (
    .clk     (clk),
    .rst     (rst),
    .wr_en   ({COLS{ld_row}}),
    .clr     ({COLS{ld_flush}}),
    .wr_data (out_data),
    .row     (m_row)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      col       <= '0;
      fill_full <= 1'b0;
      fill_sof  <= 1'b0;
      fill_idx  <= '0;
      row_cnt   <= '0;
      m_valid   <= 1'b0;
      m_sof     <= 1'b0;
      m_row_idx <= '0;
    end else begin
      if (ld_row || ld_flush) begin
        m_valid   <= 1'b1;
        m_sof     <= ld_sof;
        m_row_idx <= ld_idx;
        row_cnt   <= ld_idx_inc;
      end else begin
        if (m_ready) begin
          m_valid <= 1'b0;
        end
        if (take && s_sof) begin
          row_cnt <= '0;
        end
      end

      if (complete && !out_free) begin
        fill_full <= 1'b1;
        fill_sof  <= tag_sof;
        fill_idx  <= tag_idx;
      end else if (ld_fill) begin
        fill_full <= 1'b0;
      end

      if (take) begin
        col <= complete ? '0 : wcol + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (take) begin
            state <= complete ? EOF_NEXT : ST_FILL;
          end
        end
        ST_FILL: begin
          if (take && s_eof) begin
            state <= EOF_NEXT;
          end
        end
`ifdef SOBEL_FEEDER_FLUSH_EN
        ST_FLUSH1: begin
          if (ld_flush) begin
            state <= ST_FLUSH2;
          end
        end
        ST_FLUSH2: begin
          if (ld_flush) begin
            state <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_row_feeder.sv
`default_nettype none
// tb_sobel_row_feeder -- scoreboard bench for the row feeder at COLS = 4.
// Define SOBEL_FEEDER_FLUSH_EN on both RTL and bench to exercise the flush rows.
module tb_sobel_row_feeder;

  localparam int COLS   = 4;
  localparam int RIDX_W = 16;
  localparam int RW     = COLS * 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_sof;
  logic              s_eof;
  logic [RW-1:0]     m_row;
  logic              m_valid;
  logic              m_ready;
  logic              m_sof;
  logic [RIDX_W-1:0] m_row_idx;

  always #5 clk = ~clk;

  sobel_row_feeder #(.COLS(COLS), .RIDX_W(RIDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sof     (s_sof),
    .s_eof     (s_eof),
    .m_row     (m_row),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_sof     (m_sof),
    .m_row_idx (m_row_idx)
  );

  typedef struct packed {
    logic [RW-1:0]     row;
    logic              sof;
    logic [RIDX_W-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [RW-1:0] row4(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  function automatic void push_row(input logic [RW-1:0] r, input logic sof, input logic [RIDX_W-1:0] idx);
    exp_t e;
    e.row = r;
    e.sof = sof;
    e.idx = idx;
    exp_q.push_back(e);
  endfunction

  // Rows the feeder appends after a frame's last row.
  function automatic void push_eof(input logic [RIDX_W-1:0] last);
`ifdef SOBEL_FEEDER_FLUSH_EN
    push_row('0, 1'b0, last + 16'd1);
    push_row('0, 1'b0, last + 16'd2);
`else
    exp_q = exp_q;
    if (last == '1) exp_q = exp_q;
`endif
  endfunction

  // Monitor: every consumed row is popped from the scoreboard; stalled rows must hold.
  logic              prev_stall = 1'b0;
  logic [RW-1:0]     prev_row;
  logic              prev_sof;
  logic [RIDX_W-1:0] prev_idx;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_row !== prev_row || m_sof !== prev_sof || m_row_idx !== prev_idx) begin
          errors++;
          $display("FAIL hold: got valid=%b row=%h sof=%b idx=%0d, expected valid=1 row=%h sof=%b idx=%0d",
                   m_valid, m_row, m_sof, m_row_idx, prev_row, prev_sof, prev_idx);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_row: got row=%h sof=%b idx=%0d, expected no row", m_row, m_sof, m_row_idx);
        end else begin
          e = exp_q.pop_front();
          if (m_row !== e.row || m_sof !== e.sof || m_row_idx !== e.idx) begin
            errors++;
            $display("FAIL row: got row=%h sof=%b idx=%0d, expected row=%h sof=%b idx=%0d",
                     m_row, m_sof, m_row_idx, e.row, e.sof, e.idx);
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_row   = m_row;
      prev_sof   = m_sof;
      prev_idx   = m_row_idx;
    end
  end

  // Holds one pixel on the bus until a handshake; returns 1 ns after the accepting edge.
  task automatic send_pix(input logic [7:0] d, input logic sof, input logic eof);
    logic rdy;
    int   waited;
    waited  = 0;
    s_data  = d;
    s_sof   = sof;
    s_eof   = eof;
    s_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!rdy && waited < 100);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: pixel %0d got no handshake, expected s_ready within 100 cycles", d);
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d rows outstanding, expected 0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", m_valid); end
    checks++;
    if (m_row !== '0) begin errors++; $display("FAIL reset_row: got %h, expected 0", m_row); end
    checks++;
    if (m_sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b, expected 0", m_sof); end
    checks++;
    if (m_row_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d, expected 0", m_row_idx); end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", s_ready); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_frame();
    m_ready = 1'b1;
    for (int r = 0; r < 3; r++)
      push_row(row4(8'(4*r+1), 8'(4*r+2), 8'(4*r+3), 8'(4*r+4)), r == 0, 16'(r));
    push_eof(16'd2);
    for (int p = 1; p <= 12; p++) begin
      send_pix(8'(p), p == 1, p == 12);
      if (p % 4 == 3) begin
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL frame_early_valid: pixel %0d got %b, expected 0", p, m_valid); end
      end
      if (p % 4 == 0) begin
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL frame_latency: pixel %0d got %b, expected 1", p, m_valid); end
      end
    end
    wait_drain("frame");
  endtask

  task automatic test_stall();
    m_ready = 1'b0;
    for (int r = 0; r < 4; r++)
      push_row(row4(8'(20+4*r), 8'(21+4*r), 8'(22+4*r), 8'(23+4*r)), r == 0, 16'(r));
    push_eof(16'd3);
    for (int p = 0; p < 8; p++) begin
      send_pix(8'(20+p), p == 0, 1'b0);
      if (p == 6) begin
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_early: got %b, expected 1", s_ready); end
      end
    end
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_drop: got %b, expected 0", s_ready); end
    fork
      begin
        for (int p = 8; p < 16; p++) send_pix(8'(20+p), 1'b0, p == 15);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_held: got %b, expected 0", s_ready); end
        m_ready = 1'b1;
      end
    join
    wait_drain("stall");
  endtask

  task automatic test_presof();
    m_ready = 1'b1;
    send_pix(8'd7, 1'b0, 1'b0);
    send_pix(8'd8, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL presof_valid: cycle %0d got %b, expected 0", i, m_valid); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_restart();
    m_ready = 1'b1;
    push_row(row4(8'd60, 8'd61, 8'd62, 8'd63), 1'b1, 16'd0);
    push_row(row4(8'd50, 8'd51, 8'd52, 8'd53), 1'b1, 16'd0);
    push_row(row4(8'd54, 8'd55, 8'd56, 8'd57), 1'b0, 16'd1);
    push_eof(16'd1);
    send_pix(8'd60, 1'b1, 1'b0);
    for (int p = 61; p <= 65; p++) send_pix(8'(p), 1'b0, 1'b0);
    send_pix(8'd50, 1'b1, 1'b0);
    for (int p = 51; p <= 57; p++) send_pix(8'(p), 1'b0, p == 57);
    wait_drain("restart");
  endtask

  task automatic test_eof_partial();
    m_ready = 1'b1;
    push_row(row4(8'd1, 8'd2, 8'd3, 8'd4), 1'b1, 16'd0);
    push_row(row4(8'd9, 8'd10, 8'd0, 8'd0), 1'b0, 16'd1);
    push_eof(16'd1);
    send_pix(8'd1, 1'b1, 1'b0);
    for (int p = 2; p <= 4; p++) send_pix(8'(p), 1'b0, 1'b0);
    send_pix(8'd9, 1'b0, 1'b0);
    send_pix(8'd10, 1'b0, 1'b1);
    wait_drain("eof_partial");
  endtask

  task automatic test_single_row();
    m_ready = 1'b1;
    push_row(row4(8'd77, 8'd0, 8'd0, 8'd0), 1'b1, 16'd0);
    push_eof(16'd0);
    send_pix(8'd77, 1'b1, 1'b1);
    wait_drain("single_row");
  endtask

  task automatic test_reset_midrow();
    m_ready = 1'b1;
    send_pix(8'd90, 1'b1, 1'b0);
    send_pix(8'd91, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrow_reset: got valid=%b ready=%b, expected valid=0 ready=1", m_valid, s_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_pix(8'd92, 1'b0, 1'b0);
    send_pix(8'd93, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL midrow_lost: got valid=%b, expected 0", m_valid); end
  endtask

`ifdef SOBEL_FEEDER_FLUSH_EN
  task automatic test_flush();
    m_ready = 1'b1;
    push_row(row4(8'd1, 8'd2, 8'd3, 8'd4), 1'b1, 16'd0);
    push_row(row4(8'd5, 8'd6, 8'd7, 8'd8), 1'b0, 16'd1);
    push_eof(16'd1);
    send_pix(8'd1, 1'b1, 1'b0);
    for (int p = 2; p <= 8; p++) send_pix(8'(p), 1'b0, p == 8);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: cycle %0d got %b, expected 0", i, s_ready); end
      @(posedge clk);
      #1;
    end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_end: got %b, expected 1", s_ready); end
    wait_drain("flush");
    send_pix(8'd5, 1'b1, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush1_entry: got valid=%b ready=%b, expected valid=1 ready=0", m_valid, s_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_row !== '0 || m_sof !== 1'b0 || m_row_idx !== '0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_reset: got valid=%b row=%h sof=%b idx=%0d ready=%b, expected all zero and ready=1",
               m_valid, m_row, m_sof, m_row_idx, s_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_after_reset: got valid=%b, expected 0", m_valid); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    s_data  = '0;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
    m_ready = 1'b1;
    test_reset();
    test_frame();
    test_stall();
    test_presof();
    test_restart();
    test_eof_partial();
    test_single_row();
    test_reset_midrow();
`ifdef SOBEL_FEEDER_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
